// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IFU/LSU requesters, the arbiter and the single-port RAM.
// The arbiter takes the slave modport; the requester/RAM side takes the master modport.
interface mem_port_arbiter_if;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_gnt;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;

  logic        lsu_req;
  logic        lsu_we;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_gnt;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;

  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport master (
    output ifu_req, ifu_addr,
    output lsu_req, lsu_we, lsu_addr, lsu_wdata,
    output ram_rdata,
    input  ifu_gnt, ifu_rvalid, ifu_rdata,
    input  lsu_gnt, lsu_rvalid, lsu_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  ifu_req, ifu_addr,
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata,
    input  ram_rdata,
    output ifu_gnt, ifu_rvalid, ifu_rdata,
    output lsu_gnt, lsu_rvalid, lsu_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// IFU/LSU arbiter for one single-port RAM: combinational grant, pipelined one-cycle read return.
// Optional IFU anti-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
//
// owner state | meaning
// OWN_NONE    | no read outstanding, no rvalid this cycle
// OWN_IFU     | read granted to IFU last cycle, ifu_rvalid now
// OWN_LSU     | load granted to LSU last cycle, lsu_rvalid now
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } owner_t;

  owner_t owner_q;
  owner_t owner_d;
  logic   ifu_win;
  logic   lsu_win;
  logic   starved;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
    $error("STARVE_LIMIT must be within 1..15");
  end

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_q;

  assign starved = (starve_q == 4'(STARVE_LIMIT));

  // Counts denied IFU cycles; it cannot pass the limit because IFU wins on reaching it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= 4'd0;
    end else if (!bus.ifu_req || ifu_win) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_q + 4'd1;
    end
  end
`else
  assign starved = 1'b0;
`endif

  always_comb begin
    ifu_win = 1'b0;
    lsu_win = 1'b0;
    if (rst_n) begin
      if (bus.ifu_req && (starved || !bus.lsu_req)) begin
        ifu_win = 1'b1;
      end else if (bus.lsu_req) begin
        lsu_win = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    owner_d       = OWN_NONE;
    bus.ifu_gnt   = 1'b0;
    bus.lsu_gnt   = 1'b0;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = 32'd0;
    bus.ram_wdata = 32'd0;
    if (ifu_win) begin
      bus.ifu_gnt  = 1'b1;
      bus.ram_en   = 1'b1;
      bus.ram_addr = bus.ifu_addr;
      owner_d      = OWN_IFU;
    end else if (lsu_win) begin
      bus.lsu_gnt   = 1'b1;
      bus.ram_en    = 1'b1;
      bus.ram_we    = bus.lsu_we;
      bus.ram_addr  = bus.lsu_addr;
      bus.ram_wdata = bus.lsu_wdata;
      owner_d       = bus.lsu_we ? OWN_NONE : OWN_LSU;
    end
  end

  always_comb begin
    bus.ifu_rvalid = (owner_q == OWN_IFU);
    bus.lsu_rvalid = (owner_q == OWN_LSU);
    bus.ifu_rdata  = bus.ifu_rvalid ? bus.ram_rdata : 32'd0;
    bus.lsu_rdata  = bus.lsu_rvalid ? bus.ram_rdata : 32'd0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed cycles push expected grants/responses,
// a negedge monitor pops and compares whenever the DUT presents a grant or rvalid.
module tb_mem_port_arbiter;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam logic [1:0] W_IFU = 2'b01;
  localparam logic [1:0] W_LSU = 2'b10;

  typedef struct {
    int          cyc;
    logic [1:0]  who;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    int          cyc;
    logic [1:0]  who;
    logic [31:0] data;
  } rsp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  gnt_t gnt_q[$];
  rsp_t rsp_q[$];

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic exp_gnt(input logic [1:0] who, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata);
    gnt_t e;
    e.cyc = cyc; e.who = who; e.we = we; e.addr = addr; e.wdata = wdata;
    gnt_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic [1:0] who, input logic [31:0] data);
    rsp_t e;
    e.cyc = cyc; e.who = who; e.data = data;
    rsp_q.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic ir, input logic [31:0] ia,
                       input logic lr, input logic lw, input logic [31:0] la,
                       input logic [31:0] ld, input logic [31:0] rd);
    @(posedge clk);
    #1;
    rst_n         = rst;
    bus.ifu_req   = ir;
    bus.ifu_addr  = ia;
    bus.lsu_req   = lr;
    bus.lsu_we    = lw;
    bus.lsu_addr  = la;
    bus.lsu_wdata = ld;
    bus.ram_rdata = rd;
  endtask

  task automatic idle(input logic [31:0] rd);
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, rd);
  endtask

  // Monitor: compares on every presented grant/rvalid, flags spurious and missing events.
  always @(negedge clk) begin
    logic [1:0]  gw;
    logic [1:0]  rw;
    logic [31:0] rdat;
    gnt_t        g;
    rsp_t        r;
    gw = {bus.lsu_gnt, bus.ifu_gnt};
    rw = {bus.lsu_rvalid, bus.ifu_rvalid};
    if (gw != 2'b00) begin
      if (gnt_q.size() == 0) begin
        chk("gnt_spurious", 128'(gw), 128'd0);
      end else begin
        g = gnt_q.pop_front();
        chk("gnt", 128'({cyc, gw, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}),
                   128'({g.cyc, g.who, 1'b1, g.we, g.addr, g.wdata}));
      end
    end else begin
      chk("ram_idle", 128'({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}), 128'd0);
      if (gnt_q.size() > 0 && gnt_q[0].cyc <= cyc) begin
        g = gnt_q.pop_front();
        chk("gnt_missing", 128'({cyc, 2'b00}), 128'({g.cyc, g.who}));
      end
    end
    if (rw != 2'b00) begin
      rdat = bus.lsu_rvalid ? bus.lsu_rdata : bus.ifu_rdata;
      if (rsp_q.size() == 0) begin
        chk("rsp_spurious", 128'({rw, rdat}), 128'd0);
      end else begin
        r = rsp_q.pop_front();
        chk("rsp", 128'({cyc, rw, rdat}), 128'({r.cyc, r.who, r.data}));
      end
    end else if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
      r = rsp_q.pop_front();
      chk("rsp_missing", 128'({cyc, 2'b00}), 128'({r.cyc, r.who}));
    end
    if (!bus.ifu_rvalid) chk("ifu_rdata_zero", 128'(bus.ifu_rdata), 128'd0);
    if (!bus.lsu_rvalid) chk("lsu_rdata_zero", 128'(bus.lsu_rdata), 128'd0);
  end

  initial begin
    logic [1:0] who;
    logic [1:0] prev;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.ifu_req   = 1'b1;
    bus.ifu_addr  = 32'h100;
    bus.lsu_req   = 1'b1;
    bus.lsu_we    = 1'b0;
    bus.lsu_addr  = 32'h100;
    bus.lsu_wdata = 32'd0;
    bus.ram_rdata = 32'd0;
    prev          = W_LSU;

    // Reset held with both requests up: nothing may be granted.
    drive(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 32'h5, 32'hFFFF_FFFF);
    drive(1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 32'h5, 32'hFFFF_FFFF);
    idle(32'h0);

    // Lone IFU read.
    drive(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    exp_gnt(W_IFU, 32'h100, 1'b0, 32'd0);
    idle(32'hDEAD_BEEF);
    exp_rsp(W_IFU, 32'hDEAD_BEEF);

    // LSU store: grant is completion, no rvalid follows.
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h2000, 32'h1234_5678, 32'd0);
    exp_gnt(W_LSU, 32'h2000, 1'b1, 32'h1234_5678);
    idle(32'hAAAA_5555);

    // Simultaneous loads: LSU first, IFU next cycle.
    drive(1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 32'h3000, 32'hCAFE_0000, 32'd0);
    exp_gnt(W_LSU, 32'h3000, 1'b0, 32'hCAFE_0000);
    drive(1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 32'd0, 32'd0, 32'h1111_2222);
    exp_gnt(W_IFU, 32'h104, 1'b0, 32'd0);
    exp_rsp(W_LSU, 32'h1111_2222);
    idle(32'h3333_4444);
    exp_rsp(W_IFU, 32'h3333_4444);

    // Back-to-back reads, unaligned addresses pass through.
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'h3001, 32'd0, 32'd0);
    exp_gnt(W_LSU, 32'h3001, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 32'h107, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0A0A_0001);
    exp_gnt(W_IFU, 32'h107, 1'b0, 32'd0);
    exp_rsp(W_LSU, 32'h0A0A_0001);
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'h3003, 32'd0, 32'h0A0A_0002);
    exp_gnt(W_LSU, 32'h3003, 1'b0, 32'd0);
    exp_rsp(W_IFU, 32'h0A0A_0002);
    idle(32'h0A0A_0003);
    exp_rsp(W_LSU, 32'h0A0A_0003);
    idle(32'd0);

    // Both requests held: IFU wins only in cycle 4 when the guard is built in.
    for (int k = 0; k < 7; k++) begin
      who = (GUARD && k == 4) ? W_IFU : W_LSU;
      drive(1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h4000 + 32'(k * 4), 32'd0,
            32'hD000_0000 + 32'(k));
      if (who == W_IFU) exp_gnt(W_IFU, 32'h200, 1'b0, 32'd0);
      else              exp_gnt(W_LSU, 32'h4000 + 32'(k * 4), 1'b0, 32'd0);
      if (k > 0) exp_rsp(prev, 32'hD000_0000 + 32'(k));
      prev = who;
    end
    drive(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'd0, 32'd0, 32'hD000_0007);
    exp_gnt(W_IFU, 32'h200, 1'b0, 32'd0);
    exp_rsp(prev, 32'hD000_0007);
    idle(32'hE0E0_E0E0);
    exp_rsp(W_IFU, 32'hE0E0_E0E0);
    idle(32'd0);

    // Reset sampled right after an LSU load grant kills its rvalid.
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'h5000, 32'd0, 32'd0);
    exp_gnt(W_LSU, 32'h5000, 1'b0, 32'd0);
    #7;
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h5000, 32'd0, 32'h9999_9999);
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'h5004, 32'd0, 32'd0);
    exp_gnt(W_LSU, 32'h5004, 1'b0, 32'd0);
    idle(32'h7777_7777);
    exp_rsp(W_LSU, 32'h7777_7777);

    for (int k = 0; k < 3; k++) idle(32'h0);
    @(posedge clk);
    #1;
    chk("gnt_queue_drained", 128'(gnt_q.size()), 128'd0);
    chk("rsp_queue_drained", 128'(rsp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
